// File: rtl/riscv_multicycle.sv
// Multicycle RV32I subset core (lw/sw, add/sub/and/or/slt, addi/andi/ori/slti, beq/bne, jal).
// One shared memory port; the memory states stall until mem_ready, and illegal opcodes park the core in HALT.
`timescale 1ns/1ps
module riscv_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic            halt
);

  if (XLEN != 32) begin : g_xlen_check
    $error("riscv_multicycle: XLEN must be 32");
  end

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, HALT
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_oldpc;
  logic [XLEN-1:0] r_ir;
  logic [XLEN-1:0] r_aluout;
  logic [XLEN-1:0] r_mdr;
  logic [XLEN-1:0] r_wdata;
  logic            r_halt;
  logic [XLEN-1:0] r_regs [32];

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_f3_alu;
  logic            w_is_lw;
  logic            w_is_sw;
  logic            w_is_r;
  logic            w_is_i;
  logic            w_is_br;
  logic            w_is_jal;
  logic            w_br_taken;
  state_t          w_dec_next;
  logic [2:0]      w_alu_op;
  logic [XLEN-1:0] w_alu_b;
  logic [XLEN-1:0] w_alu_res;
  logic            w_rf_we;
  logic [XLEN-1:0] w_rf_wdata;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_funct3 = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_funct7 = r_ir[31:25];

  assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];

  // Only add/and/or/slt funct3 values are legal; sub is the single funct7 variant.
  assign w_f3_alu = (w_funct3 == 3'b000) || (w_funct3 == 3'b111) ||
                    (w_funct3 == 3'b110) || (w_funct3 == 3'b010);
  assign w_is_lw  = (w_opcode == OP_LW) && (w_funct3 == 3'b010);
  assign w_is_sw  = (w_opcode == OP_SW) && (w_funct3 == 3'b010);
  assign w_is_r   = (w_opcode == OP_R) && w_f3_alu &&
                    ((w_funct7 == 7'b0000000) ||
                     ((w_funct7 == 7'b0100000) && (w_funct3 == 3'b000)));
  assign w_is_i   = (w_opcode == OP_I) && w_f3_alu;
  assign w_is_br  = (w_opcode == OP_BR) && (w_funct3[2:1] == 2'b00);
  assign w_is_jal = (w_opcode == OP_JAL);

  assign w_br_taken = (w_funct3[0] == 1'b0) ? (w_rs1_val == w_rs2_val)
                                            : (w_rs1_val != w_rs2_val);

  always_comb begin
    w_dec_next = HALT;
    if (w_is_lw || w_is_sw) w_dec_next = MEMADR;
    else if (w_is_r)        w_dec_next = EXECR;
    else if (w_is_i)        w_dec_next = EXECI;
    else if (w_is_br)       w_dec_next = BRANCH;
    else if (w_is_jal)      w_dec_next = JAL;
  end

  always_comb begin
    w_alu_op = 3'b000;
    case (w_funct3)
      3'b000:  w_alu_op = ((r_state == EXECR) && w_funct7[5]) ? 3'b001 : 3'b000;
      3'b111:  w_alu_op = 3'b010;
      3'b110:  w_alu_op = 3'b011;
      3'b010:  w_alu_op = 3'b101;
      default: w_alu_op = 3'b000;
    endcase
  end

  assign w_alu_b = (r_state == EXECR) ? w_rs2_val : w_imm_i;

  always_comb begin
    w_alu_res = w_rs1_val + w_alu_b;
    case (w_alu_op)
      3'b001:  w_alu_res = w_rs1_val - w_alu_b;
      3'b010:  w_alu_res = w_rs1_val & w_alu_b;
      3'b011:  w_alu_res = w_rs1_val | w_alu_b;
      3'b101:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_rs1_val) < $signed(w_alu_b))};
      default: w_alu_res = w_rs1_val + w_alu_b;
    endcase
  end

  // Reset gates the write so an abandoned transfer never updates architectural state.
  assign w_rf_we    = reset && ((r_state == ALUWB) || (r_state == MEMWB)) && (w_rd != 5'd0);
  assign w_rf_wdata = (r_state == MEMWB) ? r_mdr : r_aluout;

  always_ff @(posedge clk) begin
    if (w_rf_we) r_regs[w_rd] <= w_rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_halt  <= 1'b0;
      r_ir    <= '0;
    end else begin
      case (r_state)
        FETCH: if (mem_ready) begin
          r_ir    <= mem_rdata;
          r_oldpc <= r_pc;
          r_pc    <= r_pc + 32'd4;
          r_state <= DECODE;
        end
        DECODE: begin
          r_aluout <= r_oldpc + (w_is_jal ? w_imm_j : w_imm_b);
          r_state  <= w_dec_next;
          if (w_dec_next == HALT) r_halt <= 1'b1;
        end
        MEMADR: begin
          r_aluout <= w_rs1_val + (w_is_sw ? w_imm_s : w_imm_i);
          r_wdata  <= w_rs2_val;
          r_state  <= w_is_sw ? MEMWRITE : MEMREAD;
        end
        MEMREAD: if (mem_ready) begin
          r_mdr   <= mem_rdata;
          r_state <= MEMWB;
        end
        MEMWB:    r_state <= FETCH;
        MEMWRITE: if (mem_ready) r_state <= FETCH;
        EXECR, EXECI: begin
          r_aluout <= w_alu_res;
          r_state  <= ALUWB;
        end
        ALUWB: r_state <= FETCH;
        BRANCH: begin
          if (w_br_taken) r_pc <= r_aluout;
          r_state <= FETCH;
        end
        JAL: begin
          r_pc     <= r_aluout;
          r_aluout <= r_oldpc + 32'd4;
          r_state  <= ALUWB;
        end
        HALT:    r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

  assign mem_req   = reset && ((r_state == FETCH) || (r_state == MEMREAD) || (r_state == MEMWRITE));
  assign mem_we    = reset && (r_state == MEMWRITE);
  assign mem_addr  = (r_state == FETCH) ? r_pc : r_aluout;
  assign mem_wdata = r_wdata;
  assign pc        = r_pc;
  assign halt      = r_halt;

endmodule

// File: tb/tb_riscv_multicycle.sv
// Bench for riscv_multicycle: word memory model with wait-state control and a store scoreboard.
`timescale 1ns/1ps
module tb_riscv_multicycle;

  localparam logic [31:0] B   = 32'h0000_0100;
  localparam logic [31:0] ILL = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] pc;
  logic        halt;

  riscv_multicycle #(.RESET_PC(B), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc_n = 0;
  logic        prev_req = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = '0;
  int          fetch_waits = 0;
  int          data_waits = 0;
  bit          hold_ready = 1'b0;
  bit          noise_ready = 1'b0;
  int          wcnt = 0;
  logic [31:0] mem [256];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  logic [31:0] pa;

  function automatic logic [31:0] i_op(input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] lw_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] sw_op(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_op(input logic [2:0] f3, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] j_op(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Memory model: decides mem_ready half a cycle ahead of the edge that samples it.
  always @(negedge clk) begin
    if (reset && mem_req && !hold_ready) begin
      if (wcnt < ((mem_addr < B) ? data_waits : fetch_waits)) begin
        mem_ready = 1'b0;
        wcnt++;
      end else begin
        mem_ready = 1'b1;
        wcnt = 0;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we) begin
          mem[mem_addr[9:2]] = mem_wdata;
          tests++;
          if (exp_addr.size() == 0) begin
            fails++;
            $display("FAIL store_sb: unexpected store addr=%h data=%h", mem_addr, mem_wdata);
          end else begin
            if ({mem_addr, mem_wdata} !== {exp_addr[0], exp_data[0]}) begin
              fails++;
              $display("FAIL store_sb: got addr=%h data=%h, want addr=%h data=%h",
                       mem_addr, mem_wdata, exp_addr[0], exp_data[0]);
            end
            void'(exp_addr.pop_front());
            void'(exp_data.pop_front());
          end
        end
      end
    end else begin
      mem_ready = noise_ready && !mem_req;
      wcnt = 0;
    end
  end

  task automatic cyc();
    prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr;
    @(posedge clk); #2;
    cyc_n++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = ILL;
    exp_addr.delete(); exp_data.delete();
    pa = B;
  endtask

  task automatic put(input logic [31:0] instr);
    mem[pa[9:2]] = instr;
    pa = pa + 32'd4;
  endtask

  task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
    exp_addr.push_back(a); exp_data.push_back(d);
  endtask

  // Returns the cycle on which a fetch of address a begins.
  task automatic wait_fetch(input logic [31:0] a, output int t);
    bit done = 1'b0;
    t = -1;
    for (int k = 0; k < 300 && !done; k++) begin
      if (mem_req && !mem_we && mem_addr == a && !(prev_req && !prev_we && prev_addr == a)) begin
        t = cyc_n; done = 1'b1;
      end else cyc();
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL wait_fetch: no fetch of %h within 300 cycles", a);
    end
  endtask

  task automatic wait_halt();
    bit done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (halt === 1'b1) done = 1'b1;
      else cyc();
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL wait_halt: halt not seen within 400 cycles");
    end
    tests++;
    if (exp_addr.size() != 0) begin
      fails++;
      $display("FAIL store_sb_drain: %0d expected stores never seen, want 0", exp_addr.size());
    end
  endtask

  task automatic test_reset();
    clear_mem();
    put(i_op(3'b000, 5'd0, 5'd0, 12'd0));
    reset = 1'b0;
    cyc(); cyc();
    tests++;
    if ({pc, mem_req, mem_we, halt} !== {B, 3'b000}) begin
      fails++;
      $display("FAIL reset_state: pc=%h req=%b we=%b halt=%b, want pc=%h req=0 we=0 halt=0",
               pc, mem_req, mem_we, halt, B);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, B}) begin
      fails++;
      $display("FAIL first_fetch: req=%b we=%b addr=%h, want req=1 we=0 addr=%h", mem_req, mem_we, mem_addr, B);
    end
    cyc();
    tests++;
    if (pc !== B + 32'd4) begin
      fails++;
      $display("FAIL fetch_pc: pc=%h, want %h", pc, B + 32'd4);
    end
    wait_halt();
  endtask

  task automatic test_alu();
    int t0, t3;
    clear_mem();
    put(i_op(3'b000, 5'd1, 5'd0, 12'd5));
    put(i_op(3'b000, 5'd2, 5'd0, 12'd7));
    put(r_op(7'b0000000, 3'b000, 5'd3, 5'd1, 5'd2));
    put(i_op(3'b000, 5'd0, 5'd0, 12'd9));
    put(sw_op(5'd3, 5'd0, 12'd0));  expect_store(32'd0, 32'd12);
    put(sw_op(5'd0, 5'd0, 12'd4));  expect_store(32'd4, 32'd0);
    put(r_op(7'b0100000, 3'b000, 5'd6, 5'd1, 5'd2));
    put(sw_op(5'd6, 5'd0, 12'd16)); expect_store(32'd16, 32'hFFFF_FFFE);
    put(r_op(7'b0000000, 3'b111, 5'd7, 5'd1, 5'd2));
    put(r_op(7'b0000000, 3'b110, 5'd8, 5'd1, 5'd2));
    put(r_op(7'b0000000, 3'b010, 5'd9, 5'd6, 5'd1));
    put(i_op(3'b010, 5'd10, 5'd1, 12'hFFF));
    put(i_op(3'b111, 5'd11, 5'd6, 12'h0F0));
    put(i_op(3'b110, 5'd12, 5'd1, 12'hFF0));
    put(sw_op(5'd7, 5'd0, 12'd20));  expect_store(32'd20, 32'd5);
    put(sw_op(5'd8, 5'd0, 12'd24));  expect_store(32'd24, 32'd7);
    put(sw_op(5'd9, 5'd0, 12'd28));  expect_store(32'd28, 32'd1);
    put(sw_op(5'd10, 5'd0, 12'd32)); expect_store(32'd32, 32'd0);
    put(sw_op(5'd11, 5'd0, 12'd36)); expect_store(32'd36, 32'h0000_00F0);
    put(sw_op(5'd12, 5'd0, 12'd40)); expect_store(32'd40, 32'hFFFF_FFF5);
    do_reset();
    wait_fetch(B, t0);
    wait_fetch(B + 32'd12, t3);
    tests++;
    if ((t3 - t0) != 12 || pc !== B + 32'd12) begin
      fails++;
      $display("FAIL alu_timing: cycles=%0d pc=%h, want cycles=12 pc=%h", t3 - t0, pc, B + 32'd12);
    end
    wait_halt();
  endtask

  task automatic test_mem_waits();
    int t1, t2, t3;
    clear_mem();
    data_waits = 3;
    put(i_op(3'b000, 5'd3, 5'd0, 12'd12));
    put(sw_op(5'd3, 5'd0, 12'd8));  expect_store(32'd8, 32'd12);
    put(lw_op(5'd4, 5'd0, 12'd8));
    put(sw_op(5'd4, 5'd0, 12'd12)); expect_store(32'd12, 32'd12);
    do_reset();
    wait_fetch(B + 32'd4, t1);
    cyc(); cyc(); cyc();
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'd8, 32'd12}) begin
        fails++;
        $display("FAIL sw_hold[%0d]: req=%b we=%b addr=%h wdata=%h, want 1 1 00000008 0000000c",
                 k, mem_req, mem_we, mem_addr, mem_wdata);
      end
      if (k < 3) cyc();
    end
    wait_fetch(B + 32'd8, t2);
    tests++;
    if ((t2 - t1) != 7) begin
      fails++;
      $display("FAIL sw_cycles: %0d, want 7", t2 - t1);
    end
    cyc(); cyc(); cyc();
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'd8}) begin
        fails++;
        $display("FAIL lw_hold[%0d]: req=%b we=%b addr=%h, want 1 0 00000008", k, mem_req, mem_we, mem_addr);
      end
      if (k < 3) cyc();
    end
    wait_fetch(B + 32'd12, t3);
    tests++;
    if ((t3 - t2) != 8) begin
      fails++;
      $display("FAIL lw_cycles: %0d, want 8", t3 - t2);
    end
    wait_halt();
    data_waits = 0;
  endtask

  task automatic test_branch();
    int t, t2, t3;
    noise_ready = 1'b1;
    clear_mem();
    put(i_op(3'b000, 5'd1, 5'd0, 12'd3));
    for (int i = 0; i < 3; i++) put(i_op(3'b000, 5'd0, 5'd0, 12'd0));
    put(b_op(3'b000, 5'd1, 5'd1, 13'h1FF8));
    do_reset();
    wait_fetch(B + 32'h10, t);
    cyc(); cyc();
    tests++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL branch_noreq: req=%b, want 0", mem_req);
    end
    cyc();
    tests++;
    if ({pc, mem_req, mem_addr} !== {B + 32'h08, 1'b1, B + 32'h08}) begin
      fails++;
      $display("FAIL beq_taken: pc=%h req=%b addr=%h, want pc=%h fetch %h", pc, mem_req, mem_addr, B + 32'h08, B + 32'h08);
    end
    clear_mem();
    put(i_op(3'b000, 5'd1, 5'd0, 12'd3));
    for (int i = 0; i < 3; i++) put(i_op(3'b000, 5'd0, 5'd0, 12'd0));
    put(b_op(3'b001, 5'd1, 5'd1, 13'h1FF8));
    put(i_op(3'b000, 5'd2, 5'd0, 12'd1));
    put(b_op(3'b001, 5'd1, 5'd2, 13'h0008));
    put(ILL);
    put(sw_op(5'd2, 5'd0, 12'd48)); expect_store(32'd48, 32'd1);
    put(b_op(3'b000, 5'd1, 5'd2, 13'h1FF8));
    do_reset();
    wait_fetch(B + 32'h10, t);
    cyc(); cyc(); cyc();
    tests++;
    if ({pc, mem_req, mem_addr} !== {B + 32'h14, 1'b1, B + 32'h14}) begin
      fails++;
      $display("FAIL bne_not_taken: pc=%h req=%b addr=%h, want pc=%h fetch %h", pc, mem_req, mem_addr, B + 32'h14, B + 32'h14);
    end
    wait_fetch(B + 32'h18, t2);
    wait_fetch(B + 32'h20, t3);
    tests++;
    if ((t3 - t2) != 3) begin
      fails++;
      $display("FAIL bne_taken_cycles: %0d, want 3", t3 - t2);
    end
    wait_halt();
    tests++;
    if (pc !== B + 32'h2C) begin
      fails++;
      $display("FAIL beq_not_taken: pc=%h, want %h", pc, B + 32'h2C);
    end
    noise_ready = 1'b0;
  endtask

  task automatic test_jal();
    int t, t2;
    clear_mem();
    put(i_op(3'b000, 5'd5, 5'd0, 12'd0));
    for (int i = 0; i < 7; i++) put(i_op(3'b000, 5'd0, 5'd0, 12'd0));
    put(j_op(5'd5, 21'h10));
    pa = B + 32'h30;
    put(sw_op(5'd5, 5'd0, 12'd52)); expect_store(32'd52, B + 32'h24);
    do_reset();
    wait_fetch(B + 32'h20, t);
    wait_fetch(B + 32'h30, t2);
    tests++;
    if ((t2 - t) != 4 || pc !== B + 32'h30) begin
      fails++;
      $display("FAIL jal: cycles=%0d pc=%h, want cycles=4 pc=%h", t2 - t, pc, B + 32'h30);
    end
    wait_halt();
  endtask

  task automatic test_halt_and_abort();
    int t;
    noise_ready = 1'b1;
    clear_mem();
    put(i_op(3'b000, 5'd1, 5'd0, 12'd1));
    do_reset();
    wait_fetch(B + 32'd4, t);
    cyc();
    tests++;
    if (halt !== 1'b0) begin
      fails++;
      $display("FAIL halt_early: halt=%b in decode, want 0", halt);
    end
    cyc();
    for (int k = 0; k < 20; k++) begin
      tests++;
      if ({halt, mem_req, pc} !== {2'b10, B + 32'd8}) begin
        fails++;
        $display("FAIL halt_hold[%0d]: halt=%b req=%b pc=%h, want 1 0 %h", k, halt, mem_req, pc, B + 32'd8);
      end
      cyc();
    end
    noise_ready = 1'b0;
    hold_ready = 1'b1;
    do_reset();
    cyc(); cyc();
    tests++;
    if ({halt, mem_req, mem_addr, pc} !== {2'b01, B, B}) begin
      fails++;
      $display("FAIL fetch_stall: halt=%b req=%b addr=%h pc=%h, want 0 1 %h %h", halt, mem_req, mem_addr, pc, B, B);
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({mem_req, mem_we} !== 2'b00) begin
      fails++;
      $display("FAIL abort_req: req=%b we=%b, want 0 0", mem_req, mem_we);
    end
    cyc();
    reset = 1'b1;
    #1;
    tests++;
    if ({pc, mem_req, mem_addr} !== {B, 1'b1, B}) begin
      fails++;
      $display("FAIL abort_state: pc=%h req=%b addr=%h, want %h 1 %h", pc, mem_req, mem_addr, B, B);
    end
    hold_ready = 1'b0;
    cyc();
    tests++;
    if (pc !== B + 32'd4) begin
      fails++;
      $display("FAIL abort_resume: pc=%h, want %h", pc, B + 32'd4);
    end
    wait_halt();
  endtask

  task automatic test_back_to_back();
    int t1, t2, t3;
    clear_mem();
    fetch_waits = 2;
    data_waits = 1;
    put(i_op(3'b000, 5'd1, 5'd0, 12'd9));
    put(r_op(7'b0000000, 3'b000, 5'd2, 5'd1, 5'd1));
    put(sw_op(5'd2, 5'd0, 12'd56));  expect_store(32'd56, 32'd18);
    put(r_op(7'b0100000, 3'b000, 5'd3, 5'd0, 5'd1));
    put(sw_op(5'd3, 5'd0, 12'd60));  expect_store(32'd60, 32'hFFFF_FFF7);
    do_reset();
    wait_fetch(B + 32'd4, t1);
    for (int k = 0; k < 2; k++) begin
      cyc();
      tests++;
      if ({mem_req, mem_we, mem_addr} !== {2'b10, B + 32'd4}) begin
        fails++;
        $display("FAIL fetch_hold[%0d]: req=%b we=%b addr=%h, want 1 0 %h", k, mem_req, mem_we, mem_addr, B + 32'd4);
      end
    end
    wait_fetch(B + 32'd8, t2);
    wait_fetch(B + 32'd12, t3);
    tests++;
    if ((t2 - t1) != 6 || (t3 - t2) != 7) begin
      fails++;
      $display("FAIL wait_cycles: add=%0d sw=%0d, want add=6 sw=7", t2 - t1, t3 - t2);
    end
    wait_halt();
    fetch_waits = 0;
    data_waits = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_alu();
    test_mem_waits();
    test_branch();
    test_jal();
    test_halt_and_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
